move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Game-play controller between the keypad decoder and the number/VGA datapath.
- Loads a 4-number puzzle and sequences player moves. A move is: pick operand slot A, pick operand slot B, pick operator.
- Each move applies one arithmetic step; the result goes into slot B and slot A is retired.
- After three moves it judges whether the last remaining value equals the target.
- Drives num1..num4, the valid mask and the s1/s2 selection highlights consumed by number conversion and VGA.

Parameters:
- WIDTH, 10: bit width of each number slot.
- TARGET, 24: winning value.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- start  input  1  debounced one-cycle pulse: load a new puzzle.
- restart  input  1  debounced one-cycle pulse: reload the current puzzle.
- key_valid  input  1  one-cycle strobe: key_code holds a new keypress.
- key_code  input  4  hex key value.
- m1, m2, m3, m4  input  WIDTH each  puzzle values from the puzzle source.
- num1, num2, num3, num4  output  WIDTH each  current slot values.
- valid  output  4  slot-live mask; bit0 = num1.
- s1, s2  output  3  selected slot encoding: 0 = none, 1..4 = slot.
- new_puzzle  output  1  one-cycle pulse on start; the puzzle source advances on it.
- err  output  1  one-cycle pulse on a rejected key or illegal operation.
- win, lose  output  1 each  result flags, held until the next load.

Behaviour:
- Reset values: every num = 0, valid = 0000, s1 = s2 = 0, new_puzzle/err/win/lose = 0, state IDLE, move counter = 0.
- Key map:
  - 1..4 select a slot.
  - A = add, B = subtract (A−B), C = multiply, D = divide (A/B).
  - F = clear selection.
  - Any other key is ignored with no err.
- Puzzle capture:
  - start in any state: latch m1..m4 into the nums and a shadow copy, valid = 1111, selections cleared, win/lose = 0, counter = 0, pulse new_puzzle, go to PICK1.
  - restart in any state except IDLE: same, but reload from the shadow copy and do not pulse new_puzzle.
  - restart in IDLE is ignored.
  - start wins over restart when both occur in the same cycle.
  - start/restart override any key in the same cycle.
- PICK1:
  - Key 1..4 on a live slot: s1 = slot, go to PICK2.
  - Key 1..4 on a dead slot: err.
  - A–D: err.
- PICK2:
  - Key 1..4 on a live slot different from s1: s2 = slot, go to PICKOP.
  - Same slot as s1, or a dead slot: err.
  - F: clear s1, go to PICK1.
- PICKOP:
  - A–D: go to EXEC.
  - F: clear s1/s2, go to PICK1.
  - 1..4: err.
- EXEC (exactly one cycle). Compute r = op(num[s1], num[s2]) at full precision. The move is illegal when:
  - subtract with A < B;
  - divide with B = 0 or A mod B ≠ 0;
  - add or multiply with result > 2^WIDTH−1.
- Illegal move: err pulse; slots unchanged; return to PICKOP with selections kept.
- Legal move: num[s2] = r, valid[s1] = 0, num[s1] unchanged, s1 = s2 = 0, counter++.
  - Counter = 3 after the increment: go to CHECK.
  - Otherwise go to PICK1.
- CHECK (one cycle): the single live slot equals TARGET → win = 1, else lose = 1. Go to DONE.
- DONE: all keys ignored; only start/restart act.
- Key latency: a key strobe in cycle n is visible on s1/s2/err in cycle n+1. A legal operator key shows the updated slot in n+2 and win/lose in n+3.
- The valid mask always has exactly 4 − counter bits set outside IDLE.
- Asynchronous reset mid-move returns to the reset state immediately; the shadow copy is cleared.

Test Plan:
- Win path: reset, m = 1,2,3,4, start; keys 1,2,A → num2=3, valid=1110; keys 2,3,A → num3=6, valid=1100; keys 3,4,C → num4=24, valid=1000, win=1 three cycles after the C strobe.
- Lose path: m = 1,1,1,1, three add moves → the last live value = 4, lose=1, win=0.
- Illegal ops with m = 1,2,3,4:
  - keys 1,2,B (1−2) → err, nums unchanged, state PICKOP, s1=1, s2=2.
  - Then F, then 3,2,D (3/2) → err.
  - Then F, then 4,2,D → num2=2, valid=0111.
- Selection errors:
  - Key 1, then 1 again → err, s2 stays 0.
  - After retiring slot 1, key 1 in PICK1 → err.
  - Key E anywhere → no err, no change.
- Restart mid-game: after one legal move, restart → nums = 1,2,3,4, valid=1111, counter 0, no new_puzzle. A start in the same cycle as restart → new_puzzle=1 and m is reloaded.
- Reset assertion during EXEC → all outputs zero immediately. After release, restart is ignored until start.

Source files
------------

// File: rtl/move_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_sequencer: four-number puzzle move controller (pick A, pick B, op)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module move_sequencer #(
  parameter int WIDTH  = 10,
  parameter int TARGET = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             restart_i,
  input  logic             key_valid_i,
  input  logic [3:0]       key_code_i,
  input  logic [WIDTH-1:0] m1_i,
  input  logic [WIDTH-1:0] m2_i,
  input  logic [WIDTH-1:0] m3_i,
  input  logic [WIDTH-1:0] m4_i,
  output logic [WIDTH-1:0] num1_o,
  output logic [WIDTH-1:0] num2_o,
  output logic [WIDTH-1:0] num3_o,
  output logic [WIDTH-1:0] num4_o,
  output logic [3:0]       valid_o,
  output logic [2:0]       s1_o,
  output logic [2:0]       s2_o,
  output logic             new_puzzle_o,
  output logic             err_o,
  output logic             win_o,
  output logic             lose_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK1, S_PICK2, S_PICKOP, S_EXEC, S_CHECK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q [4];
  logic [WIDTH-1:0] num_d [4];
  logic [WIDTH-1:0] shadow_q [4];
  logic [WIDTH-1:0] shadow_d [4];
  logic [WIDTH-1:0] w_m [4];
  logic [3:0]       valid_q, valid_d;
  logic [2:0]       s1_q, s1_d, s2_q, s2_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             new_puzzle_q, new_puzzle_d;
  logic             err_q, err_d;
  logic             win_q, win_d, lose_q, lose_d;

  logic             w_key_slot, w_key_op, w_key_clr;
  logic [1:0]       w_key_idx, w_ia, w_ib;
  logic [WIDTH-1:0] w_a, w_b, w_den, w_quo, w_rem, w_res, w_last;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_illegal;

  assign w_m[0] = m1_i;
  assign w_m[1] = m2_i;
  assign w_m[2] = m3_i;
  assign w_m[3] = m4_i;

  assign w_key_slot = key_valid_i && (key_code_i >= 4'd1) && (key_code_i <= 4'd4);
  assign w_key_op   = key_valid_i && (key_code_i >= 4'hA) && (key_code_i <= 4'hD);
  assign w_key_clr  = key_valid_i && (key_code_i == 4'hF);
  assign w_key_idx  = 2'(key_code_i - 4'd1);

  assign w_ia = 2'(s1_q - 3'd1);
  assign w_ib = 2'(s2_q - 3'd1);
  assign w_a  = num_q[w_ia];
  assign w_b  = num_q[w_ib];

  // Divisor forced non-zero so the divider never sees 0; that case is flagged illegal anyway.
  always_comb begin
    w_sum  = {1'b0, w_a} + {1'b0, w_b};
    w_prod = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
    w_den  = (w_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b;
    w_quo  = w_a / w_den;
    w_rem  = w_a % w_den;
    case (op_q)
      2'd0: begin
        w_res     = w_sum[WIDTH-1:0];
        w_illegal = w_sum[WIDTH];
      end
      2'd1: begin
        w_res     = w_a - w_b;
        w_illegal = (w_a < w_b);
      end
      2'd2: begin
        w_res     = w_prod[WIDTH-1:0];
        w_illegal = |w_prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_res     = w_quo;
        w_illegal = (w_b == '0) || (w_rem != '0);
      end
    endcase
  end

  always_comb begin
    w_last = '0;
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i]) w_last = num_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    shadow_d     = shadow_q;
    valid_d      = valid_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    new_puzzle_d = 1'b0;
    err_d        = 1'b0;
    win_d        = win_q;
    lose_d       = lose_q;

    if (start_i || (restart_i && state_q != S_IDLE)) begin
      for (int i = 0; i < 4; i++) begin
        num_d[i]    = start_i ? w_m[i] : shadow_q[i];
        shadow_d[i] = start_i ? w_m[i] : shadow_q[i];
      end
      valid_d      = 4'b1111;
      s1_d         = 3'd0;
      s2_d         = 3'd0;
      cnt_d        = 2'd0;
      win_d        = 1'b0;
      lose_d       = 1'b0;
      new_puzzle_d = start_i;
      state_d      = S_PICK1;
    end else begin
      case (state_q)
        S_PICK1: begin
          if (w_key_slot) begin
            if (valid_q[w_key_idx]) begin
              s1_d    = key_code_i[2:0];
              state_d = S_PICK2;
            end else begin
              err_d = 1'b1;
            end
          end else if (w_key_op) begin
            err_d = 1'b1;
          end
        end
        S_PICK2: begin
          if (w_key_slot) begin
            if (valid_q[w_key_idx] && (key_code_i[2:0] != s1_q)) begin
              s2_d    = key_code_i[2:0];
              state_d = S_PICKOP;
            end else begin
              err_d = 1'b1;
            end
          end else if (w_key_clr) begin
            s1_d    = 3'd0;
            state_d = S_PICK1;
          end else if (w_key_op) begin
            err_d = 1'b1;
          end
        end
        S_PICKOP: begin
          if (w_key_op) begin
            op_d    = 2'(key_code_i - 4'hA);
            state_d = S_EXEC;
          end else if (w_key_clr) begin
            s1_d    = 3'd0;
            s2_d    = 3'd0;
            state_d = S_PICK1;
          end else if (w_key_slot) begin
            err_d = 1'b1;
          end
        end
        S_EXEC: begin
          if (w_illegal) begin
            err_d   = 1'b1;
            state_d = S_PICKOP;
          end else begin
            num_d[w_ib]   = w_res;
            valid_d[w_ia] = 1'b0;
            s1_d          = 3'd0;
            s2_d          = 3'd0;
            cnt_d         = cnt_q + 2'd1;
            state_d       = (cnt_q == 2'd2) ? S_CHECK : S_PICK1;
          end
        end
        S_CHECK: begin
          if (w_last == WIDTH'(TARGET)) win_d  = 1'b1;
          else                          lose_d = 1'b1;
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      num_q        <= '{default: '0};
      shadow_q     <= '{default: '0};
      valid_q      <= 4'b0000;
      s1_q         <= 3'd0;
      s2_q         <= 3'd0;
      op_q         <= 2'd0;
      cnt_q        <= 2'd0;
      new_puzzle_q <= 1'b0;
      err_q        <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      shadow_q     <= shadow_d;
      valid_q      <= valid_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      new_puzzle_q <= new_puzzle_d;
      err_q        <= err_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
    end
  end

  assign num1_o       = num_q[0];
  assign num2_o       = num_q[1];
  assign num3_o       = num_q[2];
  assign num4_o       = num_q[3];
  assign valid_o      = valid_q;
  assign s1_o         = s1_q;
  assign s2_o         = s2_q;
  assign new_puzzle_o = new_puzzle_q;
  assign err_o        = err_q;
  assign win_o        = win_q;
  assign lose_o       = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_move_sequencer: directed + random key sequences vs. a game model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_move_sequencer;
  localparam int W    = 10;
  localparam int TGT  = 24;
  localparam int MAXV = (1 << W) - 1;
  localparam int P_IDLE = 0, P_PICK1 = 1, P_PICK2 = 2, P_OP = 3, P_DONE = 4;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, restart = 1'b0, key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic [W-1:0] m1 = '0, m2 = '0, m3 = '0, m4 = '0;
  logic [W-1:0] num1, num2, num3, num4;
  logic [3:0]   valid;
  logic [2:0]   s1, s2;
  logic         new_puzzle, err, win, lose;

  move_sequencer #(.WIDTH(W), .TARGET(TGT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .restart_i(restart),
    .key_valid_i(key_valid), .key_code_i(key_code),
    .m1_i(m1), .m2_i(m2), .m3_i(m3), .m4_i(m4),
    .num1_o(num1), .num2_o(num2), .num3_o(num3), .num4_o(num4),
    .valid_o(valid), .s1_o(s1), .s2_o(s2), .new_puzzle_o(new_puzzle),
    .err_o(err), .win_o(win), .lose_o(lose)
  );

  always #5 clk = ~clk;

  int n_check = 0, n_pass = 0;
  int e_num[4], e_sh[4];
  logic [3:0] e_valid;
  int e_s1, e_s2, phase, moves;
  logic e_win, e_lose;
  int ktab[16] = '{1, 2, 3, 4, 1, 2, 3, 4, 10, 11, 12, 13, 15, 14, 0, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic exp_err, input logic exp_np);
    chk({tag, ".num1"}, 32'(num1), e_num[0]);
    chk({tag, ".num2"}, 32'(num2), e_num[1]);
    chk({tag, ".num3"}, 32'(num3), e_num[2]);
    chk({tag, ".num4"}, 32'(num4), e_num[3]);
    chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
    chk({tag, ".s1"}, 32'(s1), e_s1);
    chk({tag, ".s2"}, 32'(s2), e_s2);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".new_puzzle"}, 32'(new_puzzle), 32'(exp_np));
    chk({tag, ".win"}, 32'(win), 32'(e_win));
    chk({tag, ".lose"}, 32'(lose), 32'(e_lose));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    e_num = '{0, 0, 0, 0}; e_sh = '{0, 0, 0, 0};
    e_valid = 4'b0000; e_s1 = 0; e_s2 = 0; e_win = 0; e_lose = 0;
    phase = P_IDLE; moves = 0;
  endtask

  task automatic model_load();
    e_num = e_sh; e_valid = 4'b1111; e_s1 = 0; e_s2 = 0;
    e_win = 0; e_lose = 0; moves = 0; phase = P_PICK1;
  endtask

  task automatic do_start(input int a, input int b, input int c, input int d, input logic with_rs);
    @(negedge clk);
    m1 = W'(a); m2 = W'(b); m3 = W'(c); m4 = W'(d);
    start = 1'b1; restart = with_rs;
    @(posedge clk); #1;
    start = 1'b0; restart = 1'b0;
    e_sh = '{a, b, c, d};
    model_load();
    check_all("start", 1'b0, 1'b1);
    tick();
    check_all("start_after", 1'b0, 1'b0);
  endtask

  task automatic do_restart(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    if (phase != P_IDLE) model_load();
    check_all(tag, 1'b0, 1'b0);
    tick();
    check_all({tag, "_after"}, 1'b0, 1'b0);
  endtask

  // Transaction-level model of one keypress; a move is resolved with plain integer arithmetic.
  task automatic press(input int k, input string tag);
    logic e_err, is_exec, illegal;
    int a, b, r, live, pop;
    e_err = 0; is_exec = 0; illegal = 0; r = 0;
    case (phase)
      P_PICK1:
        if (k >= 1 && k <= 4) begin
          if (e_valid[k-1]) begin e_s1 = k; phase = P_PICK2; end
          else e_err = 1;
        end else if (k >= 10 && k <= 13) e_err = 1;
      P_PICK2:
        if (k >= 1 && k <= 4) begin
          if (e_valid[k-1] && k != e_s1) begin e_s2 = k; phase = P_OP; end
          else e_err = 1;
        end else if (k == 15) begin e_s1 = 0; phase = P_PICK1; end
        else if (k >= 10 && k <= 13) e_err = 1;
      P_OP:
        if (k >= 10 && k <= 13) is_exec = 1;
        else if (k == 15) begin e_s1 = 0; e_s2 = 0; phase = P_PICK1; end
        else if (k >= 1 && k <= 4) e_err = 1;
      default: ;
    endcase
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'(k);
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'd0;
    if (!is_exec) begin
      check_all(tag, e_err, 1'b0);
      tick();
      check_all({tag, "_after"}, 1'b0, 1'b0);
    end else begin
      check_all({tag, "_exec"}, 1'b0, 1'b0);
      a = e_num[e_s1-1]; b = e_num[e_s2-1];
      case (k)
        10: begin r = a + b; illegal = (r > MAXV); end
        11: begin illegal = (a < b); r = a - b; end
        12: begin r = a * b; illegal = (r > MAXV); end
        default: begin illegal = (b == 0) || (a % b != 0); r = (b == 0) ? 0 : a / b; end
      endcase
      if (!illegal) begin
        e_num[e_s2-1] = r; e_valid[e_s1-1] = 1'b0;
        e_s1 = 0; e_s2 = 0; moves++;
        phase = (moves == 3) ? P_DONE : P_PICK1;
      end
      tick();
      check_all({tag, "_result"}, illegal, 1'b0);
      pop = 0;
      for (int i = 0; i < 4; i++) pop += int'(valid[i]);
      chk({tag, "_popcount"}, pop, 4 - moves);
      if (!illegal && moves == 3) begin
        live = 0;
        for (int i = 0; i < 4; i++) if (e_valid[i]) live = e_num[i];
        e_win = (live == TGT); e_lose = (live != TGT);
      end
      tick();
      check_all({tag, "_judge"}, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tick(); tick();
    check_all("reset", 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    do_restart("restart_idle");
    press(1, "key_idle");

    // Win path: 1+2=3, 3+3=6, 6*4=24
    do_start(1, 2, 3, 4, 1'b0);
    press(1, "w1a"); press(2, "w1b"); press(10, "w1op");
    chk("win_num2", 32'(num2), 3);
    press(2, "w2a"); press(3, "w2b"); press(10, "w2op");
    press(3, "w3a"); press(4, "w3b"); press(12, "w3op");
    chk("win_num4", 32'(num4), 24);
    chk("win_flag", 32'(win), 1);
    press(1, "done_key");

    // Lose path
    do_start(1, 1, 1, 1, 1'b0);
    press(1, "l1a"); press(2, "l1b"); press(10, "l1op");
    press(2, "l2a"); press(3, "l2b"); press(10, "l2op");
    press(3, "l3a"); press(4, "l3b"); press(10, "l3op");
    chk("lose_flag", 32'(lose), 1);

    // Illegal operations and selection errors
    do_start(1, 2, 3, 4, 1'b0);
    press(1, "i1a"); press(2, "i1b"); press(11, "i_sub");
    press(15, "i_clr1"); press(3, "i2a"); press(2, "i2b"); press(13, "i_div");
    press(15, "i_clr2"); press(4, "i3a"); press(2, "i3b"); press(13, "i_div_ok");
    chk("div_num2", 32'(num2), 2);
    press(1, "sel1"); press(1, "sel_same"); press(14, "key_e");
    press(15, "sel_clr"); press(4, "dead_slot"); press(13, "op_in_pick1");

    // Restart mid-game, then start and restart together
    do_start(1, 2, 3, 4, 1'b0);
    press(1, "r1a"); press(2, "r1b"); press(10, "r1op");
    do_restart("restart_mid");
    press(1, "r2a"); press(2, "r2b"); press(12, "r2op");
    do_start(5, 6, 7, 8, 1'b1);

    // Asynchronous reset while the move executes
    do_start(1, 2, 3, 4, 1'b0);
    press(1, "x1a"); press(2, "x1b");
    @(negedge clk); key_valid = 1'b1; key_code = 4'hA;
    @(posedge clk); #1; key_valid = 1'b0; key_code = 4'd0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset_in_exec", 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check_all("reset_release", 1'b0, 1'b0);
    do_restart("restart_after_reset");

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      do_start($urandom_range(0, 12), $urandom_range(0, 12),
               $urandom_range(1, 12), $urandom_range(0, 40), 1'b0);
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 39) == 0) do_restart("rnd_restart");
        else press(ktab[$urandom_range(0, 15)], "rnd_key");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end
endmodule
`default_nettype wire
